// File: rtl/prt_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prt_frame_scheduler
// Purpose  : Sequencing controller in front of the PRT frame buffer.
//            Ingress writes received frames into PRT slots and queues the
//            slots in arrival order. Egress offers the oldest slot for a
//            firewall verdict, then either streams it out and invalidates it
//            (accept) or only invalidates it (drop).
// Ports    : CLK/RST                       clock, synchronous active-high reset
//            rx_*                          ingress byte stream (valid/ready/last)
//            tx_*                          egress byte stream (valid/ready/last)
//            head_valid/head_slot          oldest queued frame awaiting verdict
//            verdict_valid/drop/ready      verdict handshake for the head frame
//            prt_slot_free, prt_wr_*       PRT write channel (start/data/finish)
//            prt_rd_*                      PRT read channel (start/byte read)
//            prt_inv_*                     PRT slot invalidate
//            cnt_fwd/cnt_drop              saturating frame counters
//            err_trunc                     sticky oversize-frame flag
// Revision : 1.0 - initial release
// ============================================================================
module prt_frame_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLOTS  = 2,
    parameter int MAX_LEN    = 1518
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       rx_valid,
    input  logic [DATA_WIDTH-1:0]                      rx_data,
    input  logic                                       rx_last,
    output logic                                       rx_ready,
    output logic                                       tx_valid,
    output logic [DATA_WIDTH-1:0]                      tx_data,
    output logic                                       tx_last,
    input  logic                                       tx_ready,
    output logic                                       head_valid,
    output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] head_slot,
    input  logic                                       verdict_valid,
    input  logic                                       verdict_drop,
    output logic                                       verdict_ready,
    input  logic                                       prt_slot_free,
    output logic                                       prt_wr_start_en,
    input  logic                                       prt_wr_start_rdy,
    input  logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] prt_wr_slot,
    output logic                                       prt_wr_en,
    output logic [DATA_WIDTH-1:0]                      prt_wr_data,
    output logic                                       prt_wr_fin_en,
    input  logic                                       prt_wr_fin_rdy,
    output logic                                       prt_rd_start_en,
    output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] prt_rd_slot,
    input  logic                                       prt_rd_start_rdy,
    output logic                                       prt_rd_en,
    input  logic [DATA_WIDTH:0]                        prt_rd_data,
    output logic                                       prt_inv_en,
    output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] prt_inv_slot,
    input  logic                                       prt_inv_rdy,
    output logic [15:0]                                cnt_fwd,
    output logic [15:0]                                cnt_drop,
    output logic                                       err_trunc
);

    localparam int            c_SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int            c_LW       = 11;
    localparam logic [c_SW:0] c_Q_DEPTH  = (c_SW+1)'(NUM_SLOTS);
    localparam logic [c_SW-1:0] c_Q_LAST = c_SW'(NUM_SLOTS - 1);
    localparam logic [c_LW-1:0] c_LEN_LAST = c_LW'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_REQ  = 3'd1,
        W_DATA = 3'd2,
        W_DISC = 3'd3,
        W_FIN  = 3'd4
    } w_state_t;

    typedef enum logic [2:0] {
        E_IDLE = 3'd0,
        E_RDS  = 3'd1,
        E_RD   = 3'd2,
        E_CAP  = 3'd3,
        E_OUT  = 3'd4,
        E_INV  = 3'd5
    } e_state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    w_state_t            r_w_state;
    w_state_t            w_w_next;
    e_state_t            r_e_state;
    e_state_t            w_e_next;

    logic [c_SW-1:0]     r_wr_slot;
    logic [c_LW-1:0]     r_len;
    logic                r_err_trunc;
    logic                r_wr_start_en;
    logic                r_wr_fin_en;
    logic                r_rd_start_en;
    logic                r_inv_en;

    logic [c_SW-1:0]     r_q [NUM_SLOTS];
    logic [c_SW-1:0]     r_q_wr_ptr;
    logic [c_SW-1:0]     r_q_rd_ptr;
    logic [c_SW:0]       r_q_cnt;

    logic [c_SW-1:0]     r_e_slot;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                r_tx_last;
    logic [15:0]         r_cnt_fwd;
    logic [15:0]         r_cnt_drop;

    logic                w_q_full;
    logic                w_q_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_rx_hs;
    logic                w_len_max;
    logic                w_fwd_done;

    // ------------------------------------------------------------------
    // Ingress combinational decode
    // ------------------------------------------------------------------
    assign rx_ready  = (r_w_state == W_DATA) || (r_w_state == W_DISC);
    assign w_rx_hs   = rx_valid && rx_ready;
    // The byte being accepted now is the MAX_LEN-th byte of the frame.
    assign w_len_max = (r_len == c_LEN_LAST);
    assign prt_wr_en   = (r_w_state == W_DATA) && rx_valid;
    assign prt_wr_data = prt_wr_en ? rx_data : '0;
    assign w_push      = (r_w_state == W_FIN) && prt_wr_fin_rdy;

    always_comb begin
        w_w_next = r_w_state;
        case (r_w_state)
            W_IDLE: if (rx_valid && prt_slot_free && !w_q_full) w_w_next = W_REQ;
            W_REQ:  if (prt_wr_start_rdy) w_w_next = W_DATA;
            W_DATA: begin
                if (w_rx_hs) begin
                    if (rx_last)        w_w_next = W_FIN;
                    else if (w_len_max) w_w_next = W_DISC;
                end
            end
            W_DISC: if (w_rx_hs && rx_last) w_w_next = W_FIN;
            W_FIN:  if (prt_wr_fin_rdy) w_w_next = W_IDLE;
            default: w_w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_w_state     <= W_IDLE;
            r_wr_slot     <= '0;
            r_len         <= '0;
            r_err_trunc   <= 1'b0;
            r_wr_start_en <= 1'b0;
            r_wr_fin_en   <= 1'b0;
        end else begin
            r_w_state     <= w_w_next;
            // Request pulses fire only on entry to the waiting state, so a
            // slow acknowledge never causes a second request.
            r_wr_start_en <= (w_w_next == W_REQ) && (r_w_state != W_REQ);
            r_wr_fin_en   <= (w_w_next == W_FIN) && (r_w_state != W_FIN);
            if ((r_w_state == W_REQ) && prt_wr_start_rdy) begin
                r_wr_slot <= prt_wr_slot;
                r_len     <= '0;
            end
            if ((r_w_state == W_DATA) && w_rx_hs) begin
                r_len <= r_len + 1'b1;
                if (!rx_last && w_len_max) begin
                    r_err_trunc <= 1'b1;
                end
            end
        end
    end

    assign prt_wr_start_en = r_wr_start_en;
    assign prt_wr_fin_en   = r_wr_fin_en;
    assign err_trunc       = r_err_trunc;

    // ------------------------------------------------------------------
    // Slot queue (arrival order of completely written frames)
    // ------------------------------------------------------------------
    assign w_q_full   = (r_q_cnt == c_Q_DEPTH);
    assign w_q_empty  = (r_q_cnt == '0);
    assign head_valid = !w_q_empty;
    assign head_slot  = head_valid ? r_q[r_q_rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q[r_q_wr_ptr] <= r_wr_slot;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q_wr_ptr <= '0;
            r_q_rd_ptr <= '0;
            r_q_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_q_wr_ptr <= (r_q_wr_ptr == c_Q_LAST) ? '0 : r_q_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_q_rd_ptr <= (r_q_rd_ptr == c_Q_LAST) ? '0 : r_q_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
                2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Egress FSM
    // ------------------------------------------------------------------
    assign verdict_ready = (r_e_state == E_IDLE) && head_valid;
    assign w_pop         = verdict_valid && verdict_ready;
    assign w_fwd_done    = (r_e_state == E_OUT) && tx_ready && r_tx_last;

    always_comb begin
        w_e_next = r_e_state;
        case (r_e_state)
            E_IDLE: if (w_pop) w_e_next = verdict_drop ? E_INV : E_RDS;
            E_RDS:  if (prt_rd_start_rdy) w_e_next = E_RD;
            E_RD:   w_e_next = E_CAP;
            E_CAP:  w_e_next = E_OUT;
            E_OUT:  if (tx_ready) w_e_next = r_tx_last ? E_INV : E_RD;
            E_INV:  if (prt_inv_rdy) w_e_next = E_IDLE;
            default: w_e_next = E_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_e_state     <= E_IDLE;
            r_e_slot      <= '0;
            r_tx_data     <= '0;
            r_tx_last     <= 1'b0;
            r_rd_start_en <= 1'b0;
            r_inv_en      <= 1'b0;
            r_cnt_fwd     <= '0;
            r_cnt_drop    <= '0;
        end else begin
            r_e_state     <= w_e_next;
            r_rd_start_en <= (w_e_next == E_RDS) && (r_e_state != E_RDS);
            r_inv_en      <= (w_e_next == E_INV) && (r_e_state != E_INV);
            if (w_pop) begin
                r_e_slot <= head_slot;
                if (verdict_drop && (r_cnt_drop != 16'hFFFF)) begin
                    r_cnt_drop <= r_cnt_drop + 16'd1;
                end
            end
            // PRT read data is valid the cycle after prt_rd_en.
            if (r_e_state == E_CAP) begin
                r_tx_data <= prt_rd_data[DATA_WIDTH-1:0];
                r_tx_last <= prt_rd_data[DATA_WIDTH];
            end
            if (w_fwd_done && (r_cnt_fwd != 16'hFFFF)) begin
                r_cnt_fwd <= r_cnt_fwd + 16'd1;
            end
        end
    end

    assign prt_rd_start_en = r_rd_start_en;
    assign prt_rd_slot     = r_e_slot;
    assign prt_rd_en       = (r_e_state == E_RD);
    assign prt_inv_en      = r_inv_en;
    assign prt_inv_slot    = r_e_slot;
    assign tx_valid        = (r_e_state == E_OUT);
    assign tx_data         = r_tx_data;
    assign tx_last         = r_tx_last;
    assign cnt_fwd         = r_cnt_fwd;
    assign cnt_drop        = r_cnt_drop;

endmodule
`default_nettype wire

// File: tb/tb_prt_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prt_frame_scheduler
// Purpose  : Self-checking bench for prt_frame_scheduler. A behavioural PRT
//            model answers the write/read/invalidate channels with random
//            latency; frame contents and verdict outcomes feed a scoreboard
//            that a negedge monitor compares against the egress stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prt_frame_scheduler;

    localparam int DW = 8;
    localparam int NS = 2;
    localparam int ML = 1518;
    localparam int SW = 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rx_valid = 0, rx_last = 0, tx_ready = 0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_ready, tx_valid, tx_last, head_valid, verdict_ready;
    logic [DW-1:0] tx_data, prt_wr_data;
    logic [SW-1:0] head_slot, prt_rd_slot, prt_inv_slot;
    logic          verdict_valid = 0, verdict_drop = 0;
    logic          prt_slot_free = 1, prt_wr_start_rdy = 0, prt_wr_fin_rdy = 0;
    logic          prt_rd_start_rdy = 0, prt_inv_rdy = 0;
    logic [SW-1:0] prt_wr_slot = '0;
    logic [DW:0]   prt_rd_data = '0;
    logic          prt_wr_start_en, prt_wr_en, prt_wr_fin_en, prt_rd_start_en, prt_rd_en, prt_inv_en;
    logic [15:0]   cnt_fwd, cnt_drop;
    logic          err_trunc;

    always #5 CLK = ~CLK;

    prt_frame_scheduler #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_LEN(ML)) dut (
        .CLK(CLK), .RST(RST),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .head_valid(head_valid), .head_slot(head_slot),
        .verdict_valid(verdict_valid), .verdict_drop(verdict_drop), .verdict_ready(verdict_ready),
        .prt_slot_free(prt_slot_free),
        .prt_wr_start_en(prt_wr_start_en), .prt_wr_start_rdy(prt_wr_start_rdy), .prt_wr_slot(prt_wr_slot),
        .prt_wr_en(prt_wr_en), .prt_wr_data(prt_wr_data),
        .prt_wr_fin_en(prt_wr_fin_en), .prt_wr_fin_rdy(prt_wr_fin_rdy),
        .prt_rd_start_en(prt_rd_start_en), .prt_rd_slot(prt_rd_slot), .prt_rd_start_rdy(prt_rd_start_rdy),
        .prt_rd_en(prt_rd_en), .prt_rd_data(prt_rd_data),
        .prt_inv_en(prt_inv_en), .prt_inv_slot(prt_inv_slot), .prt_inv_rdy(prt_inv_rdy),
        .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop), .err_trunc(err_trunc)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         frame_len_q[$];
    int         frame_slot_q[$];
    logic [7:0] frame_byte_q[$];
    logic [8:0] exp_tx[$];
    int         exp_rd[$];
    int         exp_inv[$];
    int         exp_fwd = 0, exp_drop = 0;
    logic       exp_trunc = 0;

    // PRT model state
    int         slot_st[NS];     // 0 free, 1 writing, 2 written
    int         mem_len[NS];
    logic [7:0] mem[NS][ML+1];
    int         cur_w, rd_s, rd_ptr, inv_s;
    bit         ws_pend, fin_pend, rs_pend, inv_pend;
    int         ws_dly, fin_dly, rs_dly, inv_dly;
    int         wr_cnt = 0, inv_cnt = 0, rds_cnt = 0;
    int         free_l[$];
    bit         hold_pend;
    logic [8:0] hold_val;
    bit         rand_mode = 0;
    int         n_v, s_v;
    logic [7:0] b_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        failures++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [63:0] outs();
        return {1'b0, rx_ready, tx_valid, tx_data, tx_last, head_valid, head_slot, verdict_ready,
                prt_wr_start_en, prt_wr_en, prt_wr_data, prt_wr_fin_en, prt_rd_start_en,
                prt_rd_slot, prt_rd_en, prt_inv_en, prt_inv_slot, cnt_fwd, cnt_drop, err_trunc};
    endfunction

    task automatic prt_reset();
        for (int k = 0; k < NS; k++) begin
            slot_st[k] = 0;
            mem_len[k] = 0;
        end
        ws_pend = 0; fin_pend = 0; rs_pend = 0; inv_pend = 0; hold_pend = 0;
        prt_wr_start_rdy = 0; prt_wr_fin_rdy = 0; prt_rd_start_rdy = 0; prt_inv_rdy = 0;
        prt_slot_free = 1; prt_rd_data = '0; prt_wr_slot = '0;
    endtask

    // PRT model and output monitor, evaluated mid-cycle on stable signals.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                prt_reset();
                continue;
            end
            prt_wr_start_rdy = 0; prt_wr_fin_rdy = 0; prt_rd_start_rdy = 0; prt_inv_rdy = 0;

            if (hold_pend) check("tx_hold", {tx_valid, tx_last, tx_data}, {1'b1, hold_val});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail("tx_unexpected_beat", int'(tx_data), -1);
                else check("tx_beat", {tx_last, tx_data}, exp_tx.pop_front());
            end
            hold_pend = tx_valid && !tx_ready;
            hold_val  = {tx_last, tx_data};

            if (verdict_valid && verdict_ready) begin
                if (frame_len_q.size() == 0 || frame_slot_q.size() == 0) begin
                    fail("verdict_without_frame", frame_len_q.size(), 1);
                end else begin
                    n_v = frame_len_q.pop_front();
                    s_v = frame_slot_q.pop_front();
                    check("head_slot", head_slot, s_v);
                    for (int i = 0; i < n_v; i++) begin
                        b_v = frame_byte_q.pop_front();
                        if (!verdict_drop) exp_tx.push_back({(i == n_v - 1), b_v});
                    end
                    if (verdict_drop) exp_drop++;
                    else begin
                        exp_fwd++;
                        exp_rd.push_back(s_v);
                    end
                    exp_inv.push_back(s_v);
                end
            end

            if (prt_wr_en) begin
                wr_cnt++;
                if (mem_len[cur_w] < ML + 1) begin
                    mem[cur_w][mem_len[cur_w]] = prt_wr_data;
                    mem_len[cur_w]++;
                end
            end
            if (prt_wr_start_en) begin
                if (ws_pend) fail("wr_start_repulse", 1, 0);
                ws_pend = 1; ws_dly = $urandom_range(0, 2);
            end
            if (ws_pend) begin
                if (ws_dly == 0) begin
                    free_l.delete();
                    for (int k = 0; k < NS; k++) if (slot_st[k] == 0) free_l.push_back(k);
                    if (free_l.size() == 0) fail("wr_start_without_free_slot", 0, 1);
                    else begin
                        s_v = free_l[$urandom_range(0, free_l.size() - 1)];
                        slot_st[s_v] = 1; mem_len[s_v] = 0; cur_w = s_v;
                        prt_wr_slot = SW'(s_v); prt_wr_start_rdy = 1;
                        frame_slot_q.push_back(s_v);
                    end
                    ws_pend = 0;
                end else ws_dly--;
            end
            if (prt_wr_fin_en) begin
                if (fin_pend) fail("wr_fin_repulse", 1, 0);
                fin_pend = 1; fin_dly = $urandom_range(0, 2);
            end
            if (fin_pend) begin
                if (fin_dly == 0) begin
                    slot_st[cur_w] = 2; prt_wr_fin_rdy = 1; fin_pend = 0;
                end else fin_dly--;
            end

            if (prt_rd_start_en) begin
                rds_cnt++;
                if (rs_pend) fail("rd_start_repulse", 1, 0);
                if (exp_rd.size() == 0) fail("rd_start_unexpected", int'(prt_rd_slot), -1);
                else check("rd_slot", prt_rd_slot, exp_rd.pop_front());
                rd_s = int'(prt_rd_slot); rd_ptr = 0;
                check("rd_slot_written", slot_st[rd_s], 2);
                rs_pend = 1; rs_dly = $urandom_range(0, 2);
            end
            if (rs_pend) begin
                if (rs_dly == 0) begin
                    prt_rd_start_rdy = 1; rs_pend = 0;
                end else rs_dly--;
            end
            if (prt_rd_en) begin
                if (rd_ptr >= mem_len[rd_s]) fail("rd_overrun", rd_ptr, mem_len[rd_s] - 1);
                else prt_rd_data = {(rd_ptr == mem_len[rd_s] - 1), mem[rd_s][rd_ptr]};
                rd_ptr++;
            end

            if (prt_inv_en) begin
                inv_cnt++;
                if (inv_pend) fail("inv_repulse", 1, 0);
                if (exp_inv.size() == 0) fail("inv_unexpected", int'(prt_inv_slot), -1);
                else check("inv_slot", prt_inv_slot, exp_inv.pop_front());
                inv_s = int'(prt_inv_slot);
                inv_pend = 1; inv_dly = $urandom_range(0, 2);
            end
            if (inv_pend) begin
                if (inv_dly == 0) begin
                    slot_st[inv_s] = 0; mem_len[inv_s] = 0; prt_inv_rdy = 1; inv_pend = 0;
                end else inv_dly--;
            end

            prt_slot_free = 0;
            for (int k = 0; k < NS; k++) if (slot_st[k] == 0) prt_slot_free = 1;
        end
    end

    // Random verdict and egress back-pressure during the random phase.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_mode) begin
                verdict_valid = ($urandom_range(0, 2) == 0);
                verdict_drop  = ($urandom_range(0, 1) == 1);
                tx_ready      = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_rx_hs(output bit ok);
        int t;
        t = 0; ok = 0;
        while (t < 3000) begin
            @(negedge CLK);
            if (rx_ready) begin
                ok = 1;
                break;
            end
            t++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input bit rnd);
        logic [7:0] b;
        bit ok;
        frame_len_q.push_back((len > ML) ? ML : len);
        if (len > ML) exp_trunc = 1;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            if (i < ML) frame_byte_q.push_back(b);
            if (rand_mode && $urandom_range(0, 3) == 0) begin
                rx_valid = 0;
                @(posedge CLK);
                #1;
            end
            rx_valid = 1; rx_data = b; rx_last = (i == len - 1);
            wait_rx_hs(ok);
            if (!ok) begin
                fail("rx_handshake_timeout", i, len);
                break;
            end
        end
        rx_valid = 0; rx_last = 0; rx_data = '0;
    endtask

    task automatic give_verdict(input bit drop);
        int t;
        t = 0;
        verdict_valid = 1; verdict_drop = drop;
        forever begin
            @(negedge CLK);
            if (verdict_ready) break;
            t++;
            if (t > 3000) begin
                fail("verdict_timeout", 0, 1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        verdict_valid = 0; verdict_drop = 0;
    endtask

    task automatic wait_drain(input int lim);
        int t;
        t = 0;
        while (exp_tx.size() != 0 || exp_inv.size() != 0 || frame_len_q.size() != 0 || inv_pend) begin
            @(negedge CLK);
            t++;
            if (t > lim) begin
                fail("drain_timeout", exp_tx.size() + exp_inv.size() + frame_len_q.size(), 0);
                break;
            end
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        bit ok;
        bit saw;
        int w0, r0, i0;

        repeat (3) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        check("reset_outputs", outs(), 64'd0);

        // Single 10-byte frame, accepted
        @(posedge CLK); #1;
        tx_ready = 1;
        send_frame(10, 8'hA0, 0);
        give_verdict(0);
        wait_drain(500);
        check("A_cnt_fwd", cnt_fwd, 1);
        check("A_inv_count", inv_cnt, 1);

        // Two queued frames fill the slots; a third must be held off
        send_frame(5, 8'h10, 0);
        send_frame(7, 8'h20, 0);
        repeat (10) @(posedge CLK);
        #1;
        rx_valid = 1; rx_data = 8'h30; rx_last = 0;
        saw = 0;
        repeat (20) begin
            @(negedge CLK);
            if (rx_ready || prt_wr_start_en) saw = 1;
        end
        check("B_backpressure", saw, 0);
        check("B_head_valid", head_valid, 1);
        check("B_head_slot", head_slot, frame_slot_q[0]);
        @(posedge CLK); #1;
        rx_valid = 0; rx_data = '0;
        give_verdict(0);
        give_verdict(0);
        wait_drain(500);
        check("B_cnt_fwd", cnt_fwd, 3);

        // Dropped frame: no read, one invalidate
        r0 = rds_cnt; i0 = inv_cnt;
        send_frame(4, 8'h40, 0);
        give_verdict(1);
        wait_drain(500);
        check("C_cnt_drop", cnt_drop, 1);
        check("C_rd_start_count", rds_cnt - r0, 0);
        check("C_inv_count", inv_cnt - i0, 1);

        // 1-byte frame held under egress back-pressure
        tx_ready = 0;
        send_frame(1, 8'h55, 0);
        give_verdict(0);
        saw = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK);
            if (tx_valid) begin
                saw = 1;
                break;
            end
        end
        check("D_tx_valid_seen", saw, 1);
        repeat (5) begin
            @(negedge CLK);
            check("D_hold_byte", {tx_valid, tx_last, tx_data}, {1'b1, 1'b1, 8'h55});
        end
        @(posedge CLK); #1;
        tx_ready = 1;
        wait_drain(500);
        check("D_cnt_fwd", cnt_fwd, 4);

        // Oversize frame truncated at MAX_LEN
        w0 = wr_cnt;
        send_frame(1600, 8'h00, 1);
        check("E_wr_count", wr_cnt - w0, ML);
        check("E_err_trunc", err_trunc, exp_trunc);
        give_verdict(0);
        wait_drain(8000);
        check("E_cnt_fwd", cnt_fwd, exp_fwd);

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1; rx_data = 8'hE0 + 8'(i); rx_last = 0;
            wait_rx_hs(ok);
            if (!ok) fail("F_rx_timeout", i, 3);
        end
        RST = 1; rx_valid = 0; rx_data = '0;
        frame_len_q.delete(); frame_slot_q.delete(); frame_byte_q.delete();
        exp_tx.delete(); exp_rd.delete(); exp_inv.delete();
        exp_fwd = 0; exp_drop = 0; exp_trunc = 0;
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        check("F_reset_outputs", outs(), 64'd0);
        @(posedge CLK); #1;
        send_frame(3, 8'h60, 0);
        give_verdict(0);
        wait_drain(500);
        check("F_cnt_fwd", cnt_fwd, 1);
        check("F_err_trunc", err_trunc, 0);

        // Random traffic, verdicts and back-pressure
        rand_mode = 1;
        for (int f = 0; f < 30; f++) begin
            send_frame($urandom_range(1, 24), 8'h00, 1);
        end
        wait_drain(20000);
        rand_mode = 0;
        #2;
        verdict_valid = 0; verdict_drop = 0; tx_ready = 1;
        repeat (5) @(negedge CLK);
        check("G_cnt_fwd", cnt_fwd, exp_fwd);
        check("G_cnt_drop", cnt_drop, exp_drop);
        check("G_head_valid", head_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prt_frame_scheduler.md
Name: prt_frame_scheduler

Overview:
- Sequencing controller in front of the PRT (packet reference table) frame buffer.
- Ingress: accepts a byte stream from the MAC receive side and drives the PRT write channel (start/data/finish). Keeps written slots in arrival order.
- Egress: presents the oldest slot for a firewall verdict. On accept, reads the frame out to the transmit stream and then invalidates the slot. On drop, invalidates the slot only.

Parameters:
- DATA_WIDTH, 8, byte width of the frame data.
- NUM_SLOTS, 2, number of PRT slots; also the slot-queue depth. SW = $clog2(NUM_SLOTS).
- MAX_LEN, 1518, maximum frame length in bytes.

Ports:
- CLK in 1: clock.
- RST in 1: reset.
- rx_valid/rx_data/rx_last in 1/DATA_WIDTH/1: ingress byte stream.
- rx_ready out 1: ingress accept.
- tx_valid/tx_data/tx_last out 1/DATA_WIDTH/1: egress byte stream.
- tx_ready in 1: egress accept.
- head_valid out 1: the oldest written frame is awaiting a verdict.
- head_slot out SW: slot index of that frame.
- verdict_valid/verdict_drop in 1/1: verdict for the head frame.
- verdict_ready out 1: verdict accept.
- prt_slot_free in 1: PRT has a free slot.
- prt_wr_start_en out 1: write-start request.
- prt_wr_start_rdy in 1: write-start acknowledge.
- prt_wr_slot in SW: slot allocated by PRT, valid with prt_wr_start_rdy.
- prt_wr_en out 1: write one byte.
- prt_wr_data out DATA_WIDTH: byte to write.
- prt_wr_fin_en out 1: write-finish request.
- prt_wr_fin_rdy in 1: write-finish acknowledge.
- prt_rd_start_en out 1: read-start request.
- prt_rd_slot out SW: slot to read.
- prt_rd_start_rdy in 1: read-start acknowledge.
- prt_rd_en out 1: read one byte.
- prt_rd_data in DATA_WIDTH+1: read byte; MSB = frame-complete flag; valid the cycle after prt_rd_en.
- prt_inv_en out 1: invalidate request.
- prt_inv_slot out SW: slot to invalidate.
- prt_inv_rdy in 1: invalidate acknowledge.
- cnt_fwd out 16: frames forwarded, saturating.
- cnt_drop out 16: frames dropped by verdict, saturating.
- err_trunc out 1: sticky; set when a frame exceeds MAX_LEN.

Interface decision: one clock, CLK. RST is synchronous and active-high. On RST every output and all state go to 0/idle and the slot queue is emptied. The PRT is reset in the same cycle by the integration. RST mid-frame abandons the frame; nothing is invalidated.

Behaviour:
Write FSM:
- W_IDLE: if rx_valid && prt_slot_free, pulse prt_wr_start_en for 1 cycle and go to W_REQ.
- W_REQ: wait for prt_wr_start_rdy; latch prt_wr_slot; go to W_DATA.
- W_DATA:
  - rx_ready=1. Each rx handshake gives prt_wr_en=1 and prt_wr_data=rx_data in the same cycle, and increments an 11-bit len counter.
  - On rx_last, go to W_FIN.
  - If len reaches MAX_LEN without rx_last, set err_trunc and go to W_DISC.
- W_DISC: rx_ready=1; discard bytes through rx_last, then go to W_FIN.
- W_FIN: pulse prt_wr_fin_en; wait for prt_wr_fin_rdy; push the slot into the queue; go to W_IDLE.
- rx_ready=0 in every state other than W_DATA and W_DISC.
- If prt_slot_free=0 or the queue is full, the FSM stays in W_IDLE (back-pressure).

Slot queue:
- FIFO, depth NUM_SLOTS, with wrap-around pointers and a count.
- head_valid = !empty; head_slot = queue head.
- Push and pop in the same cycle are allowed; count is unchanged.

Egress FSM (runs concurrently with the write FSM):
- E_IDLE: verdict_ready = head_valid. On the verdict handshake, pop the queue.
  - drop: increment cnt_drop, go to E_INV.
  - accept: go to E_RDS.
- E_RDS: pulse prt_rd_start_en with prt_rd_slot = popped slot; wait for prt_rd_start_rdy; go to E_RD.
- E_RD: pulse prt_rd_en; go to E_CAP.
- E_CAP: load tx_data = prt_rd_data[DATA_WIDTH-1:0] and tx_last = prt_rd_data[DATA_WIDTH]; tx_valid=1; go to E_OUT.
- E_OUT: hold tx_* until tx_ready.
  - Then, if tx_last: increment cnt_fwd, go to E_INV.
  - Otherwise go to E_RD.
  - Throughput is 1 byte per 3 cycles or better.
- E_INV: pulse prt_inv_en with prt_inv_slot; wait for prt_inv_rdy; go to E_IDLE.

General rules:
- All request pulses are exactly 1 cycle. While waiting for an acknowledge, the request is not re-pulsed.
- Counters hold at 16'hFFFF.
- A 1-byte frame: the first read returns complete=1, so tx_last=1 on the first beat.

Test Plan:
- Reset then 10-byte frame A0..A9, verdict accept, tx_ready=1 -> tx bytes A0..A9, tx_last only on A9; one prt_inv_en for that slot; cnt_fwd=1.
- Two frames of 5B (10..) and 7B (20..) with no verdict; third frame offered -> rx_ready stays 0 and head_slot = first slot. Then accept, accept -> output order 10..14 then 20..26.
- Verdict drop on a 4-byte frame -> no prt_rd_start_en, one prt_inv_en, cnt_drop=1, tx_valid stays 0.
- 1-byte frame 55 accepted with tx_ready held low 5 cycles -> tx_data=55 and tx_last=1 held stable until tx_ready.
- 1600-byte frame -> exactly 1518 prt_wr_en, err_trunc=1, remaining 82 bytes consumed, frame queued.
- RST asserted during W_DATA -> next cycle all outputs are 0 and head_valid=0; a subsequent 3-byte frame forwards correctly.
